uart_word_tx: RTL and testbench



---
 rtl/uart_word_tx_pkg.sv | 14 +
 rtl/uart_word_tx_sync_fifo.sv | 60 ++++++
 rtl/uart_word_tx.sv | 140 ++++++++++++++
 tb/tb_uart_word_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_word_tx_pkg.sv
// Shared types and constants for the word-oriented UART transmit path.
package uart_word_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_t;

    localparam int unsigned UART_BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_word_tx_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two >= 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the registered count, so a pop never frees space for a same-cycle push.
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word-buffered UART transmitter: 32-bit words sent as 4 bytes, MSB byte first, 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_valid,
    input  logic [31:0]                   wr_data,
    output logic                          wr_ready,
    output logic                          io_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       LAST_BYTE = 2'(UART_BYTES_PER_WORD - 1);

    uart_tx_state_t   r_state;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_byte_idx;
    logic [31:0]      r_shift;
    logic             r_tx;

    logic [31:0]      w_fifo_data;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_bit_end;
    logic [7:0]       w_cur_byte;

    assign w_pop      = (r_state == TX_IDLE) && !w_empty;
    assign w_bit_end  = (r_baud == BAUD_LAST);
    assign w_cur_byte = r_shift[31:24];

    assign wr_ready = !w_full;
    assign busy     = (r_state != TX_IDLE) || !w_empty;
    assign io_tx    = r_tx;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (wr_valid),
        .i_wdata (wr_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // r_tx is loaded with the level of the state being entered, so the line changes exactly on bit boundaries.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= TX_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            if (r_state == TX_IDLE || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift    <= w_fifo_data;
                        r_byte_idx <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= ^w_cur_byte;
                            r_state <= TX_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= TX_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (w_bit_end) begin
                        if (r_byte_idx != LAST_BYTE) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_shift    <= {r_shift[23:0], 8'h00};
                            r_tx       <= 1'b0;
                            r_state    <= TX_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: cycle-accurate waveform model derived from frame arithmetic.
module tb_uart_word_tx;

    localparam int unsigned CLK_HZ = 16;
    localparam int unsigned BAUD   = 1;
    localparam int unsigned DEPTH  = 4;
    localparam int          CPB    = 16;
`ifdef UART_TX_PARITY_EN
    localparam int          FB     = 11;
`else
    localparam int          FB     = 10;
`endif
    localparam int          L      = 4 * FB * CPB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        io_tx;
    logic        busy;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    uart_word_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .io_tx      (io_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: queued words plus the cycle window of the word on the line.
    logic [31:0] q[$];
    logic [31:0] cur = '0;
    int          cyc = 0;
    int          f_start = 0;
    int          f_end = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic exp_tx(input int i);
        int         off;
        int         k;
        int         b;
        logic [7:0] byte_v;
        if (i >= f_start && i < f_end) begin
            off    = i - f_start;
            k      = off / (FB * CPB);
            b      = (off % (FB * CPB)) / CPB;
            byte_v = 8'(cur >> (8 * (3 - k)));
            if (b == 0) return 1'b0;
            if (b <= 8) return byte_v[b-1];
            if (FB == 11 && b == 9) return ^byte_v;
            return 1'b1;
        end
        return 1'b1;
    endfunction

    function automatic logic model_busy();
        return (cyc < f_end) || (q.size() != 0);
    endfunction

    task automatic step(output bit pushed);
        bit ready;
        bit idle;
        @(posedge clk);
        cyc++;
        pushed = 1'b0;
        if (!reset_n) begin
            q.delete();
            f_start = cyc;
            f_end   = cyc;
        end else begin
            ready = (q.size() != DEPTH);
            idle  = (cyc - 1) >= f_end;
            if (idle && q.size() != 0) begin
                cur     = q.pop_front();
                f_start = cyc;
                f_end   = cyc + L;
            end
            if (wr_valid && ready) begin
                q.push_back(wr_data);
                pushed = 1'b1;
            end
        end
        @(negedge clk);
        check("io_tx", 32'(io_tx), 32'(exp_tx(cyc)));
        check("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
        check("busy", 32'(busy), 32'(model_busy()));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
    endtask

    task automatic run(input int n);
        bit p;
        for (int i = 0; i < n; i++) step(p);
    endtask

    task automatic push_word(input logic [31:0] w);
        bit p;
        wr_valid = 1'b1;
        wr_data  = w;
        p = 1'b0;
        for (int k = 0; k < 4 * L && !p; k++) step(p);
        wr_valid = 1'b0;
        if (!p) check("push_timeout", 32'(p), 32'd1);
    endtask

    task automatic drain();
        bit p;
        for (int k = 0; k < (DEPTH + 2) * (L + 1) && model_busy(); k++) step(p);
        run(3);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bit p;
        int target;

        // Reset, then a quiet line.
        reset_n = 1'b0;
        run(3);
        reset_n = 1'b1;
        run(100);

        // Single word, then a parity-sensitive word.
        push_word(32'hA1B2C3D4);
        drain();
        push_word(32'h07000000);
        drain();

        // Six words back-to-back with valid held; backpressure at four queued.
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        push_word(32'h44444444);
        push_word(32'h55555555);
        push_word(32'h66666666);
        drain();

        // Push coincident with pop while two words are queued.
        push_word(32'hDEAD0001);
        push_word(32'hDEAD0002);
        push_word(32'hDEAD0003);
        for (int k = 0; k < 2 * L && cyc < f_end; k++) step(p);
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD0004;
        step(p);
        wr_valid = 1'b0;
        check("cnt2_hold", 32'(fifo_count), 32'd2);
        drain();

        // Reset during the third data bit of the second byte, with words still queued.
        push_word(32'hCAFEF00D);
        push_word(32'h12345678);
        push_word(32'h9ABCDEF0);
        target = f_start + FB * CPB + 3 * CPB;
        for (int k = 0; k < 2 * L && cyc < target; k++) step(p);
        reset_n = 1'b0;
        step(p);
        reset_n = 1'b1;
        check("rst_tx", 32'(io_tx), 32'd1);
        check("rst_cnt", 32'(fifo_count), 32'd0);
        run(5);
        push_word(32'h5A3C0FF0);
        drain();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            wr_valid = ($urandom_range(0, 5) == 0);
            wr_data  = $urandom;
            step(p);
        end
        wr_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
